// File: rtl/robot_arm_pkg.sv
// Shared types and defaults for the robot_arm scheduler front-end.
// Included by the scheduler top and its tag FIFO.
package robot_arm_pkg;

  localparam int DEF_DATA_WIDTH_IN  = 16;
  localparam int DEF_DATA_WIDTH_OUT = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERROR
  } sched_state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/robot_arm_tag_fifo.sv
// Requester-ID tag FIFO: simultaneous push/pop, count output,
// async active-low reset and synchronous flush.
module robot_arm_tag_fifo
  import robot_arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_data  = mem_q[rd_q];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A flush discards everything, including a same-cycle push.
    if (i_flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end

endmodule

// File: rtl/robot_arm_sched.sv
// Round-robin issue scheduler for the robot_arm FK core with
// in-order tag tracking, tagged result return and a watchdog.
module robot_arm_sched
  import robot_arm_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = DEF_DATA_WIDTH_IN,
  parameter int DATA_WIDTH_OUT = DEF_DATA_WIDTH_OUT,
  parameter int N_REQ          = 2,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_REQ-1:0]                i_req_valid,
  input  logic [N_REQ*DATA_WIDTH_IN-1:0]  i_req_thi1,
  input  logic [N_REQ*DATA_WIDTH_IN-1:0]  i_req_thi2,
  input  logic [N_REQ*DATA_WIDTH_IN-1:0]  i_req_thi3,
  output logic [N_REQ-1:0]                o_req_ready,
  output logic                            o_core_thi_valid,
  output logic [DATA_WIDTH_IN-1:0]        o_core_thi1,
  output logic [DATA_WIDTH_IN-1:0]        o_core_thi2,
  output logic [DATA_WIDTH_IN-1:0]        o_core_thi3,
  input  logic                            i_core_xyz_valid,
  input  logic [DATA_WIDTH_OUT-1:0]       i_core_x,
  input  logic [DATA_WIDTH_OUT-1:0]       i_core_y,
  input  logic [DATA_WIDTH_OUT-1:0]       i_core_z,
  output logic                            o_res_valid,
  output logic [id_w(N_REQ)-1:0]          o_res_id,
  output logic [DATA_WIDTH_OUT-1:0]       o_res_x,
  output logic [DATA_WIDTH_OUT-1:0]       o_res_y,
  output logic [DATA_WIDTH_OUT-1:0]       o_res_z,
  output logic [$clog2(MAX_OUT):0]        o_outstanding,
  output logic                            o_err_timeout,
  output logic                            o_err_spurious,
  input  logic                            i_err_clr
);

  localparam int ID_W = id_w(N_REQ);
  localparam int OW   = $clog2(MAX_OUT) + 1;
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam int DWI  = DATA_WIDTH_IN;
  localparam int DWO  = DATA_WIDTH_OUT;

  sched_state_t   state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [WDW-1:0]  wd_q, wd_d;

  logic [ID_W-1:0] grant, hi_idx, lo_idx;
  logic            hi_found, lo_found;
  logic            can_issue, issue, res_ok, spur, tmo, busy_d;
  logic [DWI-1:0]  sel1, sel2, sel3;

  logic            f_full, f_empty;
  logic [ID_W-1:0] f_head;
  logic [OW-1:0]   f_count;

  logic            thi_vld_q;
  logic [DWI-1:0]  thi1_q, thi2_q, thi3_q;
  logic            res_vld_q;
  logic [ID_W-1:0] res_id_q;
  logic [DWO-1:0]  res_x_q, res_y_q, res_z_q;
  logic            etmo_q, etmo_d;
  logic            espur_q, espur_d;

  // Two scans: first valid at or above the pointer, else first overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (i_req_valid[j] && (ID_W'(j) >= rr_q)) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(j);
      end
      if (i_req_valid[j]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(j);
      end
    end
    grant = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    sel3 = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant == ID_W'(k)) begin
        sel1 = i_req_thi1[k*DWI +: DWI];
        sel2 = i_req_thi2[k*DWI +: DWI];
        sel3 = i_req_thi3[k*DWI +: DWI];
      end
    end
  end

  assign can_issue = i_rst && (state_q != ERROR) && !f_full;
  assign issue     = can_issue && lo_found;
  assign o_req_ready = issue ? (N_REQ'(1) << grant) : '0;

  assign res_ok = i_core_xyz_valid && !f_empty && (state_q != ERROR);
  assign spur   = i_core_xyz_valid && f_empty && (state_q != ERROR);

  assign tmo = (f_count != '0) && !i_core_xyz_valid
            && (wd_q == WDW'(TIMEOUT - 1));
  assign wd_d = (i_core_xyz_valid || (f_count == '0) || tmo)
              ? '0 : wd_q + WDW'(1);

  assign busy_d = issue || (f_count > OW'(1))
               || ((f_count == OW'(1)) && !res_ok);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (tmo)         state_d = ERROR;
        else if (busy_d) state_d = RUN;
        else             state_d = IDLE;
      end
      ERROR: if (i_err_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      rr_d = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

  assign etmo_d  = tmo  ? 1'b1 : (i_err_clr ? 1'b0 : etmo_q);
  assign espur_d = spur ? 1'b1 : (i_err_clr ? 1'b0 : espur_q);

  robot_arm_tag_fifo #(
    .DEPTH(MAX_OUT),
    .WIDTH(ID_W)
  ) u_tags (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (tmo),
    .i_push  (issue),
    .i_pop   (res_ok),
    .i_data  (grant),
    .o_data  (f_head),
    .o_full  (f_full),
    .o_empty (f_empty),
    .o_count (f_count)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      wd_q      <= '0;
      thi_vld_q <= 1'b0;
      thi1_q    <= '0;
      thi2_q    <= '0;
      thi3_q    <= '0;
      res_vld_q <= 1'b0;
      res_id_q  <= '0;
      res_x_q   <= '0;
      res_y_q   <= '0;
      res_z_q   <= '0;
      etmo_q    <= 1'b0;
      espur_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      thi_vld_q <= issue;
      if (issue) begin
        thi1_q <= sel1;
        thi2_q <= sel2;
        thi3_q <= sel3;
      end
      res_vld_q <= res_ok;
      if (res_ok) begin
        res_id_q <= f_head;
        res_x_q  <= i_core_x;
        res_y_q  <= i_core_y;
        res_z_q  <= i_core_z;
      end
      etmo_q  <= etmo_d;
      espur_q <= espur_d;
    end
  end

  assign o_core_thi_valid = thi_vld_q;
  assign o_core_thi1      = thi1_q;
  assign o_core_thi2      = thi2_q;
  assign o_core_thi3      = thi3_q;
  assign o_res_valid      = res_vld_q;
  assign o_res_id         = res_id_q;
  assign o_res_x          = res_x_q;
  assign o_res_y          = res_y_q;
  assign o_res_z          = res_z_q;
  assign o_outstanding    = f_count;
  assign o_err_timeout    = etmo_q;
  assign o_err_spurious   = espur_q;

endmodule

// File: tb/tb_robot_arm_sched.sv
// Bench for robot_arm_sched: randomized requesters and an in-order
// core model, checked against a transaction-level scheduler model.
module tb_robot_arm_sched;

  localparam int DWI = 16;
  localparam int DWO = 32;
  localparam int NR  = 2;
  localparam int MO  = 4;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]     req_valid = '0;
  logic [NR*DWI-1:0] req_thi1, req_thi2, req_thi3;
  logic [NR-1:0]     o_req_ready;
  logic              o_core_thi_valid;
  logic [DWI-1:0]    o_core_thi1, o_core_thi2, o_core_thi3;
  logic              core_valid = 1'b0;
  logic [DWO-1:0]    core_x = '0, core_y = '0, core_z = '0;
  logic              o_res_valid;
  logic [0:0]        o_res_id;
  logic [DWO-1:0]    o_res_x, o_res_y, o_res_z;
  logic [2:0]        o_outstanding;
  logic              o_err_timeout, o_err_spurious;
  logic              err_clr = 1'b0;

  logic [DWI-1:0] rq1 [NR];
  logic [DWI-1:0] rq2 [NR];
  logic [DWI-1:0] rq3 [NR];

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      req_thi1[k*DWI +: DWI] = rq1[k];
      req_thi2[k*DWI +: DWI] = rq2[k];
      req_thi3[k*DWI +: DWI] = rq3[k];
    end
  end

  robot_arm_sched #(
    .DATA_WIDTH_IN(DWI), .DATA_WIDTH_OUT(DWO),
    .N_REQ(NR), .MAX_OUT(MO), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid),
    .i_req_thi1(req_thi1), .i_req_thi2(req_thi2), .i_req_thi3(req_thi3),
    .o_req_ready(o_req_ready),
    .o_core_thi_valid(o_core_thi_valid),
    .o_core_thi1(o_core_thi1), .o_core_thi2(o_core_thi2),
    .o_core_thi3(o_core_thi3),
    .i_core_xyz_valid(core_valid),
    .i_core_x(core_x), .i_core_y(core_y), .i_core_z(core_z),
    .o_res_valid(o_res_valid), .o_res_id(o_res_id),
    .o_res_x(o_res_x), .o_res_y(o_res_y), .o_res_z(o_res_z),
    .o_outstanding(o_outstanding),
    .o_err_timeout(o_err_timeout),
    .o_err_spurious(o_err_spurious),
    .i_err_clr(err_clr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Scheduler reference model (transaction level).
  int m_rr, m_out, m_wd;
  bit m_err, m_tf, m_sf;
  int exp_ids[$];
  int grant_log[$];
  int peak;

  // Core / requester environment.
  int mode;
  bit core_silent;
  bit fix_x;
  int core_lat = 3;
  int core_due[$];
  logic [DWO-1:0] cq_x[$], cq_y[$], cq_z[$];

  task automatic model_reset();
    m_rr = 0; m_out = 0; m_wd = 0;
    m_err = 0; m_tf = 0; m_sf = 0;
    exp_ids.delete();
  endtask

  task automatic drive_res();
    core_valid = 1'b1;
    core_x = $urandom;
    core_y = $urandom;
    core_z = $urandom;
  endtask

  task automatic tick();
    bit any, can, iss, pop, spur, tmo;
    int g, eid;
    logic [NR-1:0] erdy;
    logic [DWI-1:0] e1, e2, e3;
    logic [DWO-1:0] ex, ey, ez;
    int d;
    #2;
    any = 0; g = 0;
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_rr + i) % NR;
      if (!any && req_valid[k]) begin any = 1; g = k; end
    end
    can = !m_err && (m_out < MO);
    iss = can && any;
    erdy = '0;
    if (iss) erdy[g] = 1'b1;
    checks++;
    if (o_req_ready !== erdy) begin
      errors++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_req_ready, erdy);
    end
    e1 = rq1[g]; e2 = rq2[g]; e3 = rq3[g];
    ex = core_x; ey = core_y; ez = core_z;
    pop = 0; spur = 0; eid = 0; tmo = 0;
    if (core_valid && !m_err) begin
      if (m_out == 0) spur = 1;
      else begin pop = 1; eid = exp_ids.pop_front(); end
    end
    if (core_valid || m_out == 0) m_wd = 0;
    else if (m_wd + 1 == TO) begin tmo = 1; m_wd = 0; end
    else m_wd++;
    if (iss) begin
      exp_ids.push_back(g);
      grant_log.push_back(g);
      m_out++;
      m_rr = (g + 1) % NR;
    end
    if (pop) m_out--;
    m_sf  = spur ? 1'b1 : (err_clr ? 1'b0 : m_sf);
    m_tf  = tmo  ? 1'b1 : (err_clr ? 1'b0 : m_tf);
    m_err = tmo  ? 1'b1 : (err_clr ? 1'b0 : m_err);
    if (tmo) begin exp_ids.delete(); m_out = 0; end

    @(posedge clk);
    #1;
    cyc++;
    checks++;
    if (o_core_thi_valid !== iss) begin
      errors++;
      $display("FAIL issue_strobe cyc=%0d got=%b exp=%b", cyc, o_core_thi_valid, iss);
    end
    if (iss) begin
      checks++;
      if ({o_core_thi1, o_core_thi2, o_core_thi3} !== {e1, e2, e3}) begin
        errors++;
        $display("FAIL issue_data cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                 cyc, o_core_thi1, o_core_thi2, o_core_thi3, e1, e2, e3);
      end
    end
    checks++;
    if (o_res_valid !== pop) begin
      errors++;
      $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, o_res_valid, pop);
    end
    if (pop) begin
      checks++;
      if (o_res_id !== 1'(eid) || {o_res_x, o_res_y, o_res_z} !== {ex, ey, ez}) begin
        errors++;
        $display("FAIL res_data cyc=%0d got id=%0d x=%h y=%h z=%h exp id=%0d x=%h y=%h z=%h",
                 cyc, o_res_id, o_res_x, o_res_y, o_res_z, eid, ex, ey, ez);
      end
    end
    checks++;
    if (o_outstanding !== 3'(m_out) || o_err_timeout !== m_tf || o_err_spurious !== m_sf) begin
      errors++;
      $display("FAIL status cyc=%0d got out=%0d tmo=%b spur=%b exp out=%0d tmo=%b spur=%b",
               cyc, o_outstanding, o_err_timeout, o_err_spurious, m_out, m_tf, m_sf);
    end
    if (int'(o_outstanding) > peak) peak = int'(o_outstanding);

    if (iss) begin
      if (mode == 0) req_valid[g] = 1'b0;
      rq1[g] = DWI'($urandom); rq2[g] = DWI'($urandom); rq3[g] = DWI'($urandom);
    end
    if (mode == 1) req_valid = '1;
    else if (mode == 2) req_valid = NR'($urandom);
    if (o_core_thi_valid && !core_silent) begin
      d = cyc + core_lat;
      if (core_due.size() > 0 && d <= core_due[$]) d = core_due[$] + 1;
      core_due.push_back(d);
      cq_x.push_back(fix_x ? 32'h1234 : $urandom);
      cq_y.push_back($urandom);
      cq_z.push_back($urandom);
    end
    core_valid = 1'b0;
    if (core_due.size() > 0 && core_due[0] == cyc + 1) begin
      void'(core_due.pop_front());
      core_valid = 1'b1;
      core_x = cq_x.pop_front();
      core_y = cq_y.pop_front();
      core_z = cq_z.pop_front();
    end
    err_clr = 1'b0;
    if (mode == 2) core_lat = $urandom_range(1, 12);
  endtask

  task automatic drain();
    int n = 0;
    mode = 0;
    req_valid = '0;
    core_silent = 0;
    while ((m_out != 0 || core_due.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (o_outstanding !== 3'd0 || n >= 300) begin
      errors++;
      $display("FAIL drain got out=%0d after %0d cycles, exp 0", o_outstanding, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if ({o_core_thi_valid, o_res_valid, o_outstanding, o_err_timeout,
         o_err_spurious, o_req_ready, o_res_x, o_core_thi1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero outputs under reset, exp all 0");
    end
    req_valid = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int c, n;
    mode = 0; core_lat = 3; fix_x = 1;
    rq1[0] = 16'd100; rq2[0] = 16'd200; rq3[0] = 16'd300;
    req_valid[0] = 1'b1;
    tick();
    c = cyc;
    checks++;
    if (!o_core_thi_valid || {o_core_thi1, o_core_thi2, o_core_thi3} !== {16'd100, 16'd200, 16'd300}) begin
      errors++;
      $display("FAIL single_issue got v=%b %0d/%0d/%0d exp 1 100/200/300",
               o_core_thi_valid, o_core_thi1, o_core_thi2, o_core_thi3);
    end
    n = 0;
    while (!o_res_valid && n < 20) begin tick(); n++; end
    checks++;
    if (!o_res_valid || cyc - c != 3 || o_res_id !== 1'b0 || o_res_x !== 32'h1234) begin
      errors++;
      $display("FAIL single_result got v=%b lat=%0d id=%0d x=%h exp 1 3 0 1234",
               o_res_valid, cyc - c, o_res_id, o_res_x);
    end
    fix_x = 0;
    drain();
  endtask

  task automatic test_contention();
    int start, bad;
    start = m_rr;
    grant_log.delete();
    peak = 0;
    core_lat = 10;
    mode = 1;
    req_valid = '1;
    repeat (40) tick();
    drain();
    bad = 0;
    for (int i = 0; i < grant_log.size(); i++)
      if (grant_log[i] != (start + i) % NR) bad++;
    checks++;
    if (bad != 0 || grant_log.size() < 8) begin
      errors++;
      $display("FAIL contention_alternate got %0d out-of-order grants of %0d",
               bad, grant_log.size());
    end
    checks++;
    if (peak != MO) begin
      errors++;
      $display("FAIL contention_peak got %0d exp %0d", peak, MO);
    end
  endtask

  task automatic test_same_cycle();
    int n = 0;
    mode = 0;
    core_silent = 1;
    req_valid = 2'b11;
    while (m_out < 2 && n < 10) begin tick(); n++; end
    req_valid[0] = 1'b1;
    drive_res();
    tick();
    checks++;
    if (o_outstanding !== 3'd2 || !o_res_valid || !o_core_thi_valid) begin
      errors++;
      $display("FAIL same_cycle got out=%0d res=%b iss=%b exp 2 1 1",
               o_outstanding, o_res_valid, o_core_thi_valid);
    end
    repeat (2) begin
      drive_res();
      tick();
    end
    checks++;
    if (o_outstanding !== 3'd0) begin
      errors++;
      $display("FAIL same_cycle_drain got out=%0d exp 0", o_outstanding);
    end
    drain();
  endtask

  task automatic test_timeout();
    int n = 0;
    mode = 0;
    core_silent = 1;
    req_valid[0] = 1'b1;
    tick();
    while (!o_err_timeout && n < 200) begin tick(); n++; end
    checks++;
    if (!o_err_timeout || n != TO || o_outstanding !== 3'd0) begin
      errors++;
      $display("FAIL timeout got flag=%b after %0d out=%0d exp 1 after %0d out 0",
               o_err_timeout, n, o_outstanding, TO);
    end
    req_valid = 2'b11;
    #2;
    checks++;
    if (o_req_ready !== 2'b00) begin
      errors++;
      $display("FAIL timeout_blocks got ready=%b exp 00", o_req_ready);
    end
    req_valid = '0;
    drive_res();
    tick();
    checks++;
    if (o_res_valid !== 1'b0 || o_err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL late_result got res=%b spur=%b exp 0 0", o_res_valid, o_err_spurious);
    end
    err_clr = 1'b1;
    tick();
    req_valid[1] = 1'b1;
    #2;
    checks++;
    if (o_req_ready === 2'b00 || o_err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got ready=%b tmo=%b exp ready!=0 tmo=0",
               o_req_ready, o_err_timeout);
    end
    drain();
  endtask

  task automatic test_spurious();
    drive_res();
    tick();
    checks++;
    if (o_err_spurious !== 1'b1 || o_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious got spur=%b res=%b exp 1 0", o_err_spurious, o_res_valid);
    end
    err_clr = 1'b1;
    tick();
    checks++;
    if (o_err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL spurious_clear got %b exp 0", o_err_spurious);
    end
  endtask

  task automatic test_random();
    mode = 2;
    core_silent = 0;
    repeat (300) tick();
    drain();
  endtask

  task automatic test_async_reset();
    int n = 0;
    int seen = 0;
    mode = 0;
    core_silent = 1;
    while (m_out < 3 && n < 20) begin
      req_valid = 2'b11;
      tick();
      n++;
    end
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      core_due.push_back(cyc + 3 + i);
      cq_x.push_back($urandom); cq_y.push_back($urandom); cq_z.push_back($urandom);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_core_thi_valid, o_res_valid, o_outstanding, o_req_ready,
         o_err_timeout, o_err_spurious, o_core_thi1} !== '0) begin
      errors++;
      $display("FAIL async_reset got out=%0d ready=%b thi_v=%b exp all 0",
               o_outstanding, o_req_ready, o_core_thi_valid);
    end
    model_reset();
    req_valid = '0;
    core_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      if (o_res_valid) seen++;
    end
    checks++;
    if (seen != 0 || o_err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got %0d results spur=%b exp 0 results spur=1",
               seen, o_err_spurious);
    end
    err_clr = 1'b1;
    tick();
    drain();
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin
      rq1[k] = DWI'($urandom); rq2[k] = DWI'($urandom); rq3[k] = DWI'($urandom);
    end
    mode = 0; core_silent = 0; fix_x = 0; peak = 0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_same_cycle();
    test_timeout();
    test_spurious();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robot_arm_sched.md
Name: robot_arm_sched

Overview:
- Front-end scheduler for the robot_arm forward-kinematics core.
- Arbitrates joint-angle triplets (thi1..thi3) from N_REQ requesters round-robin and issues them to the core, which has no ready input.
- Tracks in-flight transactions with a requester-ID tag FIFO and returns each xyz result tagged with its requester.
- Watchdog flushes and flags an error if the core stops answering.

Parameters:
- DATA_WIDTH_IN, 16, angle width (matches core).
- DATA_WIDTH_OUT, 32, coordinate width (matches core).
- N_REQ, 2, requester count (2..8).
- MAX_OUT, 4, max in-flight transactions (power of 2, equals tag FIFO depth).
- TIMEOUT, 64, cycles without a result while outstanding>0 before error.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-low.
- i_req_valid  in  N_REQ  per-requester triplet valid.
- i_req_thi1/2/3  in  N_REQ*DATA_WIDTH_IN each  packed angles, requester k at slice k.
- o_req_ready  out  N_REQ  per-requester accept.
- o_core_thi_valid  out  1  issue strobe to core.
- o_core_thi1/2/3  out  DATA_WIDTH_IN each  angles to core.
- i_core_xyz_valid  in  1  core result strobe.
- i_core_x/y/z  in  DATA_WIDTH_OUT each  core results.
- o_res_valid  out  1  tagged result strobe (no backpressure).
- o_res_id  out  $clog2(N_REQ) (min 1)  requester of result.
- o_res_x/y/z  out  DATA_WIDTH_OUT each  result data.
- o_outstanding  out  $clog2(MAX_OUT)+1  in-flight count.
- o_err_timeout  out  1  sticky timeout flag.
- o_err_spurious  out  1  sticky flag: result with empty tag FIFO.
- i_err_clr  in  1  clears both sticky flags and leaves ERROR.

Behaviour:
- Reset (i_rst=0, async): all outputs 0, state IDLE, RR pointer=0, FIFO empty, counters 0.
- States:
  - IDLE: outstanding=0.
  - RUN: outstanding>0.
  - ERROR: issue blocked.
  - IDLE->RUN on issue. RUN->IDLE when the last result pops with no same-cycle issue. RUN->ERROR on timeout. ERROR->IDLE on i_err_clr.
- can_issue = state!=ERROR and outstanding<MAX_OUT.
- Arbitration: round-robin starting at the RR pointer. Grant goes to the first requester with valid=1. o_req_ready is combinational, one-hot at the grant when can_issue, else all 0.
- On handshake (valid&ready):
  - Triplet registered to o_core_thi*; o_core_thi_valid pulses for exactly 1 cycle (next cycle).
  - Grant ID pushed to the tag FIFO.
  - RR pointer = grant+1 mod N_REQ.
  - Issue rate: at most 1 per cycle.
- o_core_thi* hold their last value when no issue.
- Result path:
  - i_core_xyz_valid with FIFO non-empty pops the head ID.
  - o_res_valid/o_res_id/o_res_x/y/z are registered, latency 1 cycle.
  - Results return in issue order; the core is in-order.
- Simultaneous issue and result in the same cycle: outstanding unchanged, push and pop both occur. A full FIFO with a same-cycle pop still blocks issue (ready is not based on the pop).
- Result with FIFO empty, or any result in ERROR: data dropped, o_res_valid stays 0. o_err_spurious is set only when not in ERROR.
- Watchdog:
  - Counter clears on any result or whenever outstanding=0.
  - Increments while outstanding>0.
  - When it reaches TIMEOUT: enter ERROR, set o_err_timeout, flush FIFO, outstanding=0.
- i_err_clr in a non-ERROR state clears the sticky flags only. If i_err_clr coincides with a new timeout, the timeout wins.
- Widths: outstanding counter saturates by construction (issue is gated). No arithmetic on data; the scheduler is pass-through.

Decomposition:
- Package robot_arm_pkg:
  - DATA_WIDTH_IN/OUT defaults.
  - sched_state_t enum {IDLE, RUN, ERROR}.
  - ID width function.
- Sub-module robot_arm_tag_fifo:
  - Parameterised depth/width synchronous FIFO.
  - Push/pop allowed in the same cycle.
  - Provides full/empty/count.
  - Async active-low reset plus synchronous flush input.

Test Plan:
- Single request, N_REQ=2: req0 thi=(100,200,300) -> core sees o_core_thi_valid 1 cycle later with (100,200,300). Core model (latency 3) returns x=0x1234 -> o_res_valid 1 cycle later, o_res_id=0, o_res_x=0x1234.
- Contention: req0 and req1 valid continuously -> grants alternate 0,1,0,1. o_res_id sequence matches. Issue stalls after 4 with core latency 10, and o_outstanding peaks at 4.
- Same-cycle issue and result at outstanding=2 -> o_outstanding stays 2 and FIFO order is preserved.
- Timeout, TIMEOUT=64: issue 1, core silent -> after 64 cycles o_err_timeout=1, o_outstanding=0, ready=0. A late result is dropped. i_err_clr -> IDLE and ready returns.
- Spurious: i_core_xyz_valid with nothing issued -> o_err_spurious=1, o_res_valid=0.
- Async reset asserted mid-burst with 3 outstanding -> outputs 0 immediately, no o_res_valid after release.
